// File: rtl/repsub_div.sv
// repsub_div -- unsigned divider using repeated subtraction, one subtraction
// per clock.
//
// Ports:
//   clk       : clock, all state updates on the rising edge
//   rst_n     : asynchronous active-low reset
//   start     : begin a division (sampled only while idle)
//   a, b      : dividend / divisor, captured on an accepted start
//   busy      : high while a division is running or its result is being flagged
//   done      : one-cycle pulse, results valid
//   quotient  : unsigned quotient (held until the next result)
//   remainder : unsigned remainder (held until the next result)
//   div_zero  : set when the captured divisor was zero
module repsub_div #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (b == '0) ? DONE : RUN;
      RUN:  if (rem < dvs) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode straight from the state flops, so there is no path
  // from any input to busy/done.
  always_comb begin
    busy = (state == RUN) || (state == DONE);
    done = (state == DONE);
  end

  // Datapath: working registers and held result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (b == '0) begin
              // Divide by zero skips RUN and publishes its result at once.
              quotient  <= '1;
              remainder <= a;
              div_zero  <= 1'b1;
            end else begin
              rem      <= a;
              quo      <= '0;
              dvs      <= b;
              div_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          // The compare guards the subtraction, so rem never underflows.
          if (rem >= dvs) begin
            rem <= rem - dvs;
            quo <= quo + 1'b1;
          end else begin
            quotient  <= quo;
            remainder <= rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_repsub_div.sv
module tb_repsub_div;
  localparam int W = 5;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int errors = 0;
  int checks = 0;

  repsub_div #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one start (single cycle) and observe until done. lat is the number
  // of edges after the start-sampling edge at which done was seen (-1 on
  // timeout). Ends one edge after the done cycle so the caller can check that
  // the block went back to idle.
  task automatic do_div(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit scramble, output int lat,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dz, output bit busy_ok);
    busy_ok = 1'b1;
    lat = -1;
    q = '0;
    r = '0;
    dz = 1'b0;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (scramble) begin
      a = W'($urandom);
      b = W'($urandom);
    end
    for (int n = 0; n < 200; n++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat = n;
        q = quotient;
        r = remainder;
        dz = div_zero;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_zero} !== '0) begin
      errors++;
      $display("FAIL reset_async: got busy=%b done=%b q=%0d r=%0d dz=%b want all 0",
               busy, done, quotient, remainder, div_zero);
    end
    start = 1'b1;
    a = 5'd9;
    b = 5'd2;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_zero} !== '0) begin
      errors++;
      $display("FAIL reset_held: got busy=%b done=%b q=%0d r=%0d dz=%b want all 0",
               busy, done, quotient, remainder, div_zero);
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Checks one full operation against plain integer division.
  task automatic check_op(input string tag, input int av, input int bv,
                          input bit scramble);
    int lat;
    int exp_q;
    int exp_r;
    int exp_lat;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [W-1:0] hq;
    logic [W-1:0] hr;
    logic dz;
    logic hdz;
    bit busy_ok;
    exp_q   = (bv == 0) ? (1 << W) - 1 : av / bv;
    exp_r   = (bv == 0) ? av : av % bv;
    exp_lat = (bv == 0) ? 0 : av / bv + 1;
    do_div(W'(av), W'(bv), scramble, lat, q, r, dz, busy_ok);
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s_latency %0d/%0d: got %0d want %0d", tag, av, bv, lat, exp_lat);
    end
    checks++;
    if ({q, r, dz} !== {W'(exp_q), W'(exp_r), (bv == 0)}) begin
      errors++;
      $display("FAIL %s_result %0d/%0d: got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
               tag, av, bv, q, r, dz, exp_q, exp_r, bv == 0);
    end
    checks++;
    if (!busy_ok || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_handshake %0d/%0d: got busy_ok=%0d busy=%b done=%b want 1 0 0",
               tag, av, bv, busy_ok, busy, done);
    end
    // Results must hold while idle regardless of the inputs.
    hq = quotient;
    hr = remainder;
    hdz = div_zero;
    a = W'($urandom);
    b = W'($urandom);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({quotient, remainder, div_zero} !== {W'(exp_q), W'(exp_r), (bv == 0)} ||
        {hq, hr, hdz} !== {W'(exp_q), W'(exp_r), (bv == 0)}) begin
      errors++;
      $display("FAIL %s_hold %0d/%0d: got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
               tag, av, bv, quotient, remainder, div_zero, exp_q, exp_r, bv == 0);
    end
  endtask

  task automatic test_directed();
    int va[6] = '{20, 31, 7, 0, 13, 13};
    int vb[6] = '{4, 1, 9, 3, 0, 5};
    for (int i = 0; i < 6; i++) check_op("directed", va[i], vb[i], 1'b0);
  endtask

  task automatic test_random();
    int av;
    int bv;
    for (int i = 0; i < 40; i++) begin
      av = int'($urandom_range(0, (1 << W) - 1));
      bv = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, (1 << W) - 1));
      check_op("random", av, bv, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    a = 5'd17;
    b = 5'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 5'd30;
    b = 5'd2;
    lat = -1;
    for (int n = 0; n < 200; n++) begin
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (lat != 4 || quotient !== 5'd3 || remainder !== 5'd2 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d dz=%b want lat=4 q=3 r=2 dz=0",
               lat, quotient, remainder, div_zero);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_not_accepted_at_done: got busy=%b done=%b want 0 0", busy, done);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accepted_next: got busy=%b want 1", busy);
    end
    lat = -1;
    for (int n = 0; n < 200; n++) begin
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (lat != 16 || quotient !== 5'd15 || remainder !== 5'd0 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d dz=%b want lat=16 q=15 r=0 dz=0",
               lat, quotient, remainder, div_zero);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midrun();
    bit saw_done;
    @(negedge clk);
    a = 5'd25;
    b = 5'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_zero} !== '0) begin
      errors++;
      $display("FAIL midrun_reset_async: got busy=%b done=%b q=%0d r=%0d dz=%b want all 0",
               busy, done, quotient, remainder, div_zero);
    end
    saw_done = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) saw_done = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL midrun_abort: got done/busy activity=1 want 0");
    end
    check_op("after_reset", 9, 4, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
